// File: rtl/instr_enc.sv
// RV32I instruction encoder feeding a DEPTH-entry result FIFO; 1-cycle latency from accept to valid_o.
// Backpressure: ready_o = not full (never from ready_i); a full FIFO stalls requests until the consumer pops.
module instr_enc #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic [7:0]  err_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];
  logic [DEPTH-1:0] err_mem_q, err_mem_d;

  logic [31:0] enc_word, enc_instr;
  logic        enc_ok, enc_err;
  logic        push, pop;

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b0;
    case (fmt_i)
      3'd0: begin
        enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        enc_ok   = 1'b1;
      end
      3'd1: begin
        enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        enc_ok   = (&imm_i[31:11]) | ~(|imm_i[31:11]);
      end
      3'd2: begin
        enc_word = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
        enc_ok   = ~(|imm_i[31:5]);
      end
      3'd3: begin
        enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        enc_ok   = (&imm_i[31:11]) | ~(|imm_i[31:11]);
      end
      3'd4: begin
        enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
        enc_ok   = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];
      end
      3'd5: begin
        enc_word = {imm_i[31:12], rd_i, opcode_i};
        enc_ok   = ~(|imm_i[11:0]);
      end
      3'd6: begin
        enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        enc_ok   = ((&imm_i[31:20]) | ~(|imm_i[31:20])) & ~imm_i[0];
      end
      default: begin
        enc_word = '0;
        enc_ok   = 1'b0;
      end
    endcase
    enc_err   = ~enc_ok;
    enc_instr = enc_ok ? enc_word : NOP;
  end

  // Gating with rst_ni keeps ready_o low for the whole reset window.
  assign ready_o   = rst_ni & (count_q != CW'(DEPTH));
  assign valid_o   = (count_q != '0);
  assign push      = valid_i & ready_o;
  assign pop       = valid_o & ready_i;
  assign instr_o   = valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign err_o     = valid_o & err_mem_q[rd_ptr_q];
  assign err_cnt_o = err_cnt_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_cnt_d   = err_cnt_q;
    instr_mem_d = instr_mem_q;
    err_mem_d   = err_mem_q;
    if (push) begin
      instr_mem_d[wr_ptr_q] = enc_instr;
      err_mem_d[wr_ptr_q]   = enc_err;
      wr_ptr_d              = wr_ptr_q + AW'(1);
      if (enc_err && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage needs no reset: every read is masked by valid_o.
  always_ff @(posedge clk_i) begin
    instr_mem_q <= instr_mem_d;
    err_mem_q   <= err_mem_d;
  end

endmodule

// File: tb/tb_instr_enc.sv
// Scoreboard bench for instr_enc: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_instr_enc;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_ni, valid_i, ready_o, valid_o, ready_i, err_o;
  logic [2:0]  fmt_i, funct3_i;
  logic [6:0]  opcode_i, funct7_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [31:0] imm_i, instr_o;
  logic [7:0]  err_cnt_o;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  bit   acc;

  instr_enc #(.DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .fmt_i(fmt_i), .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .err_o(err_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference model from the RV32I field rules, using signed ranges for the immediate checks.
  function automatic logic [32:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] w, base;
    bit ok;
    int v;
    v = $signed(imm);
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (f)
      3'd0: begin ok = 1; w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7); end
      3'd1: begin ok = (v >= -2048 && v <= 2047); w = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7); end
      3'd2: begin ok = (imm < 32); w = (32'(f7) << 25) | ((imm & 32'h1F) << 20) | base | (32'(rd) << 7); end
      3'd3: begin
        ok = (v >= -2048 && v <= 2047);
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1F) << 7);
      end
      3'd4: begin
        ok = (v >= -4096 && v <= 4095 && (v % 2 == 0));
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) | base
          | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      end
      3'd5: begin ok = ((imm & 32'hFFF) == 0); w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op); end
      3'd6: begin
        ok = (v >= -(1 << 20) && v < (1 << 20) && (v % 2 == 0));
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
          | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
      end
      default: begin ok = 0; w = 32'h0; end
    endcase
    if (!ok) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  always @(negedge clk) begin
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h want no output", instr_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_instr", instr_o, mon_e.instr);
        chk("sb_err", 32'(err_o), 32'(mon_e.err));
      end
    end else if (valid_o === 1'b0) begin
      chk("idle_zero", instr_o | 32'(err_o), 32'h0);
    end
  end

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input logic [31:0] ei, input logic ee, input int max_wait,
      output bit ok);
    fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; imm_i = imm; valid_i = 1'b1;
    ok = 0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (ready_o) begin
        exp_q.push_back({ei, ee});
        ok = 1;
        if (ee && exp_cnt < 255) exp_cnt++;
      end
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic send_rand(input int max_wait, output bit ok);
    logic [2:0] f, f3;
    logic [6:0] op, f7;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
    logic [32:0] r;
    int v;
    f = 3'($urandom); f3 = 3'($urandom); op = 7'($urandom); f7 = 7'($urandom);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    case ($urandom % 5)
      0: imm = $urandom_range(0, 40);
      1: imm = $urandom;
      2: imm = $urandom & 32'hFFFFF000;
      3: begin v = int'($urandom_range(0, 10000)) - 5000; imm = v; end
      default: begin v = int'($urandom_range(0, 4000000)) - 2000000; imm = v; end
    endcase
    r = ref_enc(f, op, rd, rs1, rs2, f3, f7, imm);
    send(f, op, rd, rs1, rs2, f3, f7, imm, r[31:0], r[32], max_wait, ok);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(valid_o), 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    fmt_i = '0; opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
    funct3_i = '0; funct7_i = '0; imm_i = '0;
    #2;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_errcnt", 32'(err_cnt_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(ready_o), 32'd1);

    // addi x2,x6,5 held at the head so latency and contents are visible
    send(3'd1, 7'b0010011, 5'd2, 5'd6, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00530113, 1'b0, 4, acc);
    chk("addi_acc", 32'(acc), 32'd1);
    chk("addi_valid", 32'(valid_o), 32'd1);
    chk("addi_instr", instr_o, 32'h00530113);
    chk("addi_err", 32'(err_o), 32'd0);
    ready_i = 1'b1;
    wait_drain();

    send(3'd4, 7'b1100011, 5'd0, 5'd3, 5'd2, 3'b100, 7'd0, 32'hFFFFFFE6, 32'hFE21C3E3, 1'b0, 4, acc);
    send(3'd5, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0, 4, acc);
    send(3'd5, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h00000013, 1'b1, 4, acc);
    chk("u_err_cnt", 32'(err_cnt_o), 32'd1);
    wait_drain();

    // Backpressure: DEPTH accepts, then a stalled errored request that must leave no trace
    ready_i = 1'b0;
    for (int i = 0; i < D; i++) begin
      send_rand(1, acc);
      chk("fill_acc", 32'(acc), 32'd1);
    end
    chk("full_ready", 32'(ready_o), 32'd0);
    send(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h13, 1'b1, 3, acc);
    chk("full_reject", 32'(acc), 32'd0);
    chk("full_errcnt", 32'(err_cnt_o), 32'(exp_cnt));
    ready_i = 1'b1;
    wait_drain();

    // Streaming: one accept per cycle with simultaneous push and pop
    for (int i = 0; i < 40; i++) begin
      send_rand(1, acc);
      chk("stream_acc", 32'(acc), 32'd1);
    end
    wait_drain();
    chk("stream_errcnt", 32'(err_cnt_o), 32'(exp_cnt));

    fork
      begin
        repeat (300) begin
          @(posedge clk);
          #1 ready_i = 1'($urandom);
        end
        ready_i = 1'b1;
      end
      begin
        for (int i = 0; i < 100; i++) begin
          send_rand(64, acc);
          if (!acc) chk("rand_acc", 32'(acc), 32'd1);
        end
      end
    join
    ready_i = 1'b1;
    wait_drain();
    chk("rand_errcnt", 32'(err_cnt_o), 32'(exp_cnt));

    for (int i = 0; i < 260; i++) begin
      send(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h13, 1'b1, 4, acc);
    end
    wait_drain();
    chk("sat_errcnt", 32'(err_cnt_o), 32'd255);

    // Mid-stream reset with two entries buffered and err count 3
    rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    chk("clr_errcnt", 32'(err_cnt_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send(3'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'h00001000, 32'h13, 1'b1, 4, acc);
    end
    wait_drain();
    ready_i = 1'b0;
    send(3'd5, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0, 4, acc);
    send(3'd5, 7'b0110111, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 32'hABCDE337, 1'b0, 4, acc);
    chk("pre_rst_errcnt", 32'(err_cnt_o), 32'd3);
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_errcnt", 32'(err_cnt_o), 32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd0);
    chk("mid_rst_instr", instr_o, 32'd0);
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1 rst_ni = 1'b1;
    ready_i = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("no_stale", 32'(valid_o), 32'd0);
    end
    chk("post_ready", 32'(ready_o), 32'd1);
    send(3'd1, 7'b0010011, 5'd2, 5'd6, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00530113, 1'b0, 4, acc);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
